// File: rtl/multisim_client_channel.sv
// Client side of one multisim server channel: a one-entry payload buffer that
// either pulls data from the server (GET) or pushes data to it (PUT).
module multisim_client_channel #(
  parameter int DATA_WIDTH  = 64,
  parameter int IS_PUSH     = 0,
  parameter int ID_WIDTH    = 16,
  parameter int RETRY_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ID_WIDTH-1:0]   server_id,
  output logic [DATA_WIDTH-1:0] pull_data,
  output logic                  pull_vld,
  input  logic                  pull_rdy,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_vld,
  output logic                  push_rdy,
  output logic                  link_req_valid,
  input  logic                  link_req_ready,
  output logic                  link_req_op,
  output logic [ID_WIDTH-1:0]   link_req_id,
  output logic [DATA_WIDTH-1:0] link_req_data,
  input  logic                  link_rsp_valid,
  input  logic                  link_rsp_ack,
  input  logic [DATA_WIDTH-1:0] link_rsp_data,
  output logic [1:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a source holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, BACKOFF = 2'd3} state_t;

  localparam int  CW   = $clog2(RETRY_DELAY + 1);
  localparam bit  PUSH = (IS_PUSH != 0);

  state_t                state;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [CW-1:0]         bo_cnt;
  logic                  run_q;
  logic                  req_op;
  logic [ID_WIDTH-1:0]   req_id;
  logic [DATA_WIDTH-1:0] req_data;

  logic cfg;
  logic pull_take;
  logic push_take;
  logic trigger;

  assign cfg       = (server_id != '0);
  assign pull_take = !PUSH && buf_full && pull_rdy;
  assign push_take = push_rdy && push_vld;
  // Pull mode also fires on the cycle the consumer drains the buffer, which
  // gives the three-cycle beat period with an immediate server.
  assign trigger   = cfg && (PUSH ? buf_full : (!buf_full || pull_take));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      buf_data <= '0;
      bo_cnt   <= '0;
      run_q    <= 1'b0;
      req_op   <= 1'b0;
      req_id   <= '0;
      req_data <= '0;
    end else begin
      run_q <= 1'b1;
      if (pull_take) buf_full <= 1'b0;
      if (push_take) begin
        buf_full <= 1'b1;
        buf_data <= push_data;
      end
      case (state)
        IDLE: begin
          if (trigger) begin
            state    <= REQ;
            req_op   <= PUSH;
            req_id   <= server_id;
            req_data <= PUSH ? buf_data : '0;
          end
        end
        REQ: begin
          if (link_req_ready) state <= WAIT;
        end
        WAIT: begin
          if (link_rsp_valid) begin
            if (link_rsp_ack) begin
              state <= IDLE;
              if (PUSH) begin
                buf_full <= 1'b0;
              end else begin
                buf_full <= 1'b1;
                buf_data <= link_rsp_data;
              end
            end else begin
              state  <= BACKOFF;
              bo_cnt <= '0;
            end
          end
        end
        BACKOFF: begin
          // A retry is a new request, so it waits for a valid channel id.
          if (bo_cnt == CW'(RETRY_DELAY - 1)) begin
            bo_cnt <= '0;
            if (cfg) begin
              state  <= REQ;
              req_id <= server_id;
            end else begin
              state <= IDLE;
            end
          end else begin
            bo_cnt <= bo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pull_vld       = !PUSH && buf_full;
  assign pull_data      = PUSH ? '0 : buf_data;
  assign push_rdy       = PUSH && run_q && !buf_full && cfg;
  assign link_req_valid = (state == REQ);
  assign link_req_op    = req_op;
  assign link_req_id    = req_id;
  assign link_req_data  = req_data;
  assign dbg_state      = state;

endmodule

// File: tb/tb_multisim_client_channel.sv
// Directed bench: one pull-mode and one push-mode channel driven through
// ack, NACK/backoff, stall, unconfigured and reset-in-WAIT scenarios.
module tb_multisim_client_channel;

  localparam int DW = 8;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Pull instance signals
  logic [IW-1:0] p_server_id;
  logic [DW-1:0] p_pull_data, p_link_req_data, p_link_rsp_data;
  logic          p_pull_vld, p_pull_rdy, p_push_rdy;
  logic          p_link_req_valid, p_link_req_ready, p_link_req_op;
  logic [IW-1:0] p_link_req_id;
  logic          p_link_rsp_valid, p_link_rsp_ack;
  logic [1:0]    p_dbg_state;

  // Push instance signals
  logic [IW-1:0] u_server_id;
  logic [DW-1:0] u_pull_data, u_push_data, u_link_req_data, u_link_rsp_data;
  logic          u_pull_vld, u_push_vld, u_push_rdy;
  logic          u_link_req_valid, u_link_req_ready, u_link_req_op;
  logic [IW-1:0] u_link_req_id;
  logic          u_link_rsp_valid, u_link_rsp_ack;
  logic [1:0]    u_dbg_state;

  multisim_client_channel #(.DATA_WIDTH(DW), .IS_PUSH(0), .ID_WIDTH(IW), .RETRY_DELAY(4)) u_pull (
    .clk(clk), .rst_n(rst_n), .server_id(p_server_id),
    .pull_data(p_pull_data), .pull_vld(p_pull_vld), .pull_rdy(p_pull_rdy),
    .push_data(8'h00), .push_vld(1'b0), .push_rdy(p_push_rdy),
    .link_req_valid(p_link_req_valid), .link_req_ready(p_link_req_ready),
    .link_req_op(p_link_req_op), .link_req_id(p_link_req_id), .link_req_data(p_link_req_data),
    .link_rsp_valid(p_link_rsp_valid), .link_rsp_ack(p_link_rsp_ack),
    .link_rsp_data(p_link_rsp_data), .dbg_state(p_dbg_state)
  );

  multisim_client_channel #(.DATA_WIDTH(DW), .IS_PUSH(1), .ID_WIDTH(IW), .RETRY_DELAY(4)) u_push (
    .clk(clk), .rst_n(rst_n), .server_id(u_server_id),
    .pull_data(u_pull_data), .pull_vld(u_pull_vld), .pull_rdy(1'b1),
    .push_data(u_push_data), .push_vld(u_push_vld), .push_rdy(u_push_rdy),
    .link_req_valid(u_link_req_valid), .link_req_ready(u_link_req_ready),
    .link_req_op(u_link_req_op), .link_req_id(u_link_req_id), .link_req_data(u_link_req_data),
    .link_rsp_valid(u_link_rsp_valid), .link_rsp_ack(u_link_rsp_ack),
    .link_rsp_data(u_link_rsp_data), .dbg_state(u_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Any push-channel request seen while its id is 0 is a violation.
  logic u_unconf_req = 1'b0;
  always @(negedge clk)
    if (rst_n === 1'b1 && u_server_id == '0 && u_link_req_valid === 1'b1) u_unconf_req = 1'b1;

  task automatic wait_p_req(input string tag);
    int n = 0;
    while (p_link_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, p_link_req_valid, 1);
  endtask

  task automatic wait_u_req(input string tag);
    int n = 0;
    while (u_link_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, u_link_req_valid, 1);
  endtask

  task automatic p_rsp(input logic ack, input logic [DW-1:0] d);
    p_link_rsp_valid = 1'b1;
    p_link_rsp_ack   = ack;
    p_link_rsp_data  = d;
  endtask

  task automatic u_rsp(input logic ack);
    u_link_rsp_valid = 1'b1;
    u_link_rsp_ack   = ack;
    u_link_rsp_data  = '0;
  endtask

  initial begin
    int  lows;
    logic ok;
    rst_n = 1'b0;
    p_server_id = 8'd5; p_pull_rdy = 1'b1; p_link_req_ready = 1'b1;
    p_link_rsp_valid = 1'b0; p_link_rsp_ack = 1'b0; p_link_rsp_data = '0;
    u_server_id = 8'd0; u_push_data = '0; u_push_vld = 1'b0; u_link_req_ready = 1'b1;
    u_link_rsp_valid = 1'b0; u_link_rsp_ack = 1'b0; u_link_rsp_data = '0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_p_req_valid", p_link_req_valid, 0);
    check("rst_p_pull_vld", p_pull_vld, 0);
    check("rst_p_pull_data", p_pull_data, 0);
    check("rst_p_req_id", p_link_req_id, 0);
    check("rst_p_state", p_dbg_state, 0);
    check("rst_u_push_rdy", u_push_rdy, 0);
    check("rst_u_req_op", u_link_req_op, 0);
    rst_n = 1'b1;

    // Pull: immediate ack with 0xA5
    wait_p_req("p_get1_seen");
    check("p_get1_id", p_link_req_id, 5);
    check("p_get1_op", p_link_req_op, 0);
    check("p_get1_data", p_link_req_data, 0);
    @(negedge clk);
    check("p_wait_req_low", p_link_req_valid, 0);
    p_rsp(1'b1, 8'hA5);
    @(negedge clk);
    p_link_rsp_valid = 1'b0;
    check("p_ack_vld", p_pull_vld, 1);
    check("p_ack_data", p_pull_data, 8'hA5);
    @(negedge clk);
    check("p_consumed", p_pull_vld, 0);
    check("p_throughput_req", p_link_req_valid, 1);

    // Pull: NACK then exactly 4 idle cycles before the retry
    @(negedge clk);
    p_rsp(1'b0, 8'h00);
    @(negedge clk);
    p_link_rsp_valid = 1'b0;
    lows = 0;
    while (p_link_req_valid !== 1'b1 && lows < 20) begin
      lows++;
      @(negedge clk);
    end
    check("p_backoff_len", lows, 4);

    // Pull: consumer stall holds 0x3C and blocks new GETs
    p_pull_rdy = 1'b0;
    @(negedge clk);
    p_rsp(1'b1, 8'h3C);
    @(negedge clk);
    p_link_rsp_valid = 1'b0;
    check("p_stall_vld", p_pull_vld, 1);
    check("p_stall_data", p_pull_data, 8'h3C);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (p_pull_vld !== 1'b1 || p_pull_data !== 8'h3C || p_link_req_valid !== 1'b0) ok = 1'b0;
    end
    check("p_stall_hold", ok, 1);
    p_pull_rdy = 1'b1;
    @(negedge clk);
    check("p_stall_release_vld", p_pull_vld, 0);
    check("p_stall_release_req", p_link_req_valid, 1);

    // Unconfigured push channel stayed quiet all along
    check("u_unconf_rdy", u_push_rdy, 0);
    check("u_unconf_no_req", u_unconf_req, 0);

    // Pull: reset while in WAIT, then a late ack with 0xFF
    @(negedge clk);
    check("p_state_wait", p_dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("p_rst_wait_state", p_dbg_state, 0);
    check("p_rst_wait_req", p_link_req_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p_rsp(1'b1, 8'hFF);
    @(negedge clk);
    p_link_rsp_valid = 1'b0;
    check("p_late_ack_vld", p_pull_vld, 0);
    check("p_late_ack_data", p_pull_data, 0);
    check("p_fresh_get", p_link_req_valid, 1);

    // Push: configure, push 0x11 with link_req_ready held off 3 cycles
    u_server_id = 8'd7;
    @(negedge clk);
    check("u_cfg_rdy", u_push_rdy, 1);
    u_push_vld = 1'b1; u_push_data = 8'h11;
    @(negedge clk);
    u_push_vld = 1'b0;
    u_link_req_ready = 1'b0;
    check("u_full_rdy", u_push_rdy, 0);
    wait_u_req("u_put1_seen");
    check("u_put1_id", u_link_req_id, 7);
    check("u_put1_op", u_link_req_op, 1);
    check("u_put1_data", u_link_req_data, 8'h11);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (u_link_req_valid !== 1'b1 || u_link_req_data !== 8'h11 || u_push_rdy !== 1'b0) ok = 1'b0;
    end
    check("u_put1_stable", ok, 1);
    u_link_req_ready = 1'b1;
    @(negedge clk);
    u_rsp(1'b1);
    @(negedge clk);
    u_link_rsp_valid = 1'b0;
    check("u_put1_ack_rdy", u_push_rdy, 1);

    // Push: 0x22, NACKed once, retried with the same payload
    u_push_vld = 1'b1; u_push_data = 8'h22;
    @(negedge clk);
    u_push_vld = 1'b0;
    wait_u_req("u_put2_seen");
    check("u_put2_data", u_link_req_data, 8'h22);
    @(negedge clk);
    u_rsp(1'b0);
    @(negedge clk);
    u_link_rsp_valid = 1'b0;
    check("u_nack_rdy", u_push_rdy, 0);
    wait_u_req("u_retry_seen");
    check("u_retry_data", u_link_req_data, 8'h22);
    @(negedge clk);
    u_rsp(1'b1);
    @(negedge clk);
    u_link_rsp_valid = 1'b0;
    check("u_put2_ack_rdy", u_push_rdy, 1);
    u_server_id = 8'd0;
    #1;
    check("u_cfg_loss_rdy", u_push_rdy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
